// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port, with a
// busy scoreboard of in-flight destinations and a RAW/WAW hazard stall for issue.
module regfile_wb_arbiter #(
  parameter int XLEN      = 32,
  parameter int NREG_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               req_valid,
  input  logic [3*NREG_BITS-1:0]   req_rd,
  input  logic [3*XLEN-1:0]        req_data,
  output logic [2:0]               req_ready,
  output logic                     wb_en,
  output logic [NREG_BITS-1:0]     wb_rd,
  output logic [XLEN-1:0]          wb_data,
  input  logic                     sb_set,
  input  logic [NREG_BITS-1:0]     sb_set_rd,
  input  logic                     sb_flush,
  input  logic [NREG_BITS-1:0]     chk_rs1,
  input  logic [NREG_BITS-1:0]     chk_rs2,
  output logic                     hazard,
  output logic [2**NREG_BITS-1:0]  busy_vec
);

  localparam int NREG = 2**NREG_BITS;
  localparam logic [NREG_BITS-1:0] RD_ZERO = {NREG_BITS{1'b0}};

  logic [1:0]           p_q, p_d;
  logic                 wb_en_q, wb_en_d;
  logic [NREG_BITS-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]      wb_data_q, wb_data_d;
  logic [NREG-1:0]      busy_q, busy_d;

  logic [1:0]           idx1_s, idx2_s, sel_s;
  logic                 xfer_s;
  logic [NREG_BITS-1:0] sel_rd_s;
  logic [XLEN-1:0]      sel_data_s;

  always_comb begin
    idx1_s = (p_q == 2'd2) ? 2'd0 : p_q + 2'd1;
    idx2_s = (p_q == 2'd0) ? 2'd2 : p_q - 2'd1;
    req_ready = 3'b000;
    sel_s     = 2'd0;
    if (rst) begin
      req_ready = 3'b000;
    end else if (req_valid[p_q]) begin
      req_ready[p_q] = 1'b1;
      sel_s          = p_q;
    end else if (req_valid[idx1_s]) begin
      req_ready[idx1_s] = 1'b1;
      sel_s             = idx1_s;
    end else if (req_valid[idx2_s]) begin
      req_ready[idx2_s] = 1'b1;
      sel_s             = idx2_s;
    end else begin
      req_ready = 3'b000;
    end
    xfer_s = |req_ready;
  end

  always_comb begin
    case (sel_s)
      2'd1: begin
        sel_rd_s   = req_rd[NREG_BITS +: NREG_BITS];
        sel_data_s = req_data[XLEN +: XLEN];
      end
      2'd2: begin
        sel_rd_s   = req_rd[2*NREG_BITS +: NREG_BITS];
        sel_data_s = req_data[2*XLEN +: XLEN];
      end
      default: begin
        sel_rd_s   = req_rd[0 +: NREG_BITS];
        sel_data_s = req_data[0 +: XLEN];
      end
    endcase
  end

  // Pointer and write-port next state; rd=0 transfers advance p but never write.
  always_comb begin
    p_d       = p_q;
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (xfer_s) begin
      p_d       = (sel_s == 2'd2) ? 2'd0 : sel_s + 2'd1;
      wb_en_d   = (sel_rd_s != RD_ZERO);
      wb_rd_d   = sel_rd_s;
      wb_data_d = sel_data_s;
    end else begin
      p_d = p_q;
    end
  end

  // Set after clear so a newer in-flight writer wins; flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (wb_en_q) begin
      busy_d[wb_rd_q] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (sb_set && (sb_set_rd != RD_ZERO)) begin
      busy_d[sb_set_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    if (sb_flush) begin
      busy_d = {NREG{1'b0}};
    end else begin
      busy_d[0] = 1'b0;
    end
  end

  always_comb begin
    hazard = ((chk_rs1 != RD_ZERO) && busy_q[chk_rs1]) ||
             ((chk_rs2 != RD_ZERO) && busy_q[chk_rs2]) ||
             (sb_set && (sb_set_rd != RD_ZERO) && busy_q[sb_set_rd]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q       <= 2'd0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= RD_ZERO;
      wb_data_q <= {XLEN{1'b0}};
      busy_q    <= {NREG{1'b0}};
    end else begin
      p_q       <= p_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wb_en    = wb_en_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vectors and sequences, then random
// traffic compared cycle by cycle against a behavioural model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [4:0]  rd_a [3];
  logic [31:0] data_a [3];
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        sb_set, sb_flush;
  logic [4:0]  sb_set_rd, chk_rs1, chk_rs2;
  logic        hazard;
  logic [31:0] busy_vec;

  always #5 clk = ~clk;

  assign req_rd   = {rd_a[2], rd_a[1], rd_a[0]};
  assign req_data = {data_a[2], data_a[1], data_a[0]};

  regfile_wb_arbiter #(.XLEN(32), .NREG_BITS(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(req_ready), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .sb_set(sb_set), .sb_set_rd(sb_set_rd),
    .sb_flush(sb_flush), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .hazard(hazard), .busy_vec(busy_vec)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_p = 0;
  bit          m_wb_en = 1'b0;
  bit [4:0]    m_wb_rd = 5'd0;
  bit [31:0]   m_wb_data = 32'd0;
  bit [31:0]   m_busy = 32'd0;
  logic [2:0]  last_ready;
  logic        last_hazard;

  typedef struct {
    logic [2:0] valid;
    logic [2:0] exp_ready;
    logic [4:0] exp_rd;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_hazard();
    return (chk_rs1 != 5'd0 && m_busy[chk_rs1]) ||
           (chk_rs2 != 5'd0 && m_busy[chk_rs2]) ||
           (sb_set && sb_set_rd != 5'd0 && m_busy[sb_set_rd]);
  endfunction

  // One clock: check combinational outputs mid-cycle, advance model, check registers.
  task automatic step();
    int g;
    logic [2:0] er;
    bit [31:0] nb;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        int s;
        s = (m_p + k) % 3;
        if (g < 0 && req_valid[s]) g = s;
      end
    end
    er = (g < 0) ? 3'b000 : 3'(3'b001 << g);
    last_ready  = req_ready;
    last_hazard = hazard;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("hazard", 32'(hazard), 32'(m_hazard()));
    nb = m_busy;
    if (m_wb_en) nb[m_wb_rd] = 1'b0;
    if (sb_set && sb_set_rd != 5'd0) nb[sb_set_rd] = 1'b1;
    if (sb_flush) nb = 32'd0;
    if (rst) begin
      m_p = 0; m_wb_en = 1'b0; m_wb_rd = 5'd0; m_wb_data = 32'd0; m_busy = 32'd0;
    end else begin
      m_busy = nb;
      if (g >= 0) begin
        m_p       = (g + 1) % 3;
        m_wb_en   = (rd_a[g] != 5'd0);
        m_wb_rd   = rd_a[g];
        m_wb_data = data_a[g];
      end else begin
        m_wb_en = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("wb_en", 32'(wb_en), 32'(m_wb_en));
    chk("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
    chk("wb_data", wb_data, m_wb_data);
    chk("busy_vec", busy_vec, m_busy);
  endtask

  initial begin
    tbl[0]  = '{3'b111, 3'b001, 5'd1};
    tbl[1]  = '{3'b111, 3'b010, 5'd2};
    tbl[2]  = '{3'b111, 3'b100, 5'd3};
    tbl[3]  = '{3'b111, 3'b001, 5'd1};
    tbl[4]  = '{3'b111, 3'b010, 5'd2};
    tbl[5]  = '{3'b111, 3'b100, 5'd3};
    tbl[6]  = '{3'b110, 3'b010, 5'd2};
    tbl[7]  = '{3'b101, 3'b100, 5'd3};
    tbl[8]  = '{3'b001, 3'b001, 5'd1};
    tbl[9]  = '{3'b000, 3'b000, 5'd0};
    tbl[10] = '{3'b011, 3'b010, 5'd2};
    tbl[11] = '{3'b001, 3'b001, 5'd1};

    rst = 1'b1; req_valid = 3'b000; sb_set = 1'b0; sb_set_rd = 5'd0; sb_flush = 1'b0;
    chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    for (int i = 0; i < 3; i++) begin rd_a[i] = 5'd0; data_a[i] = 32'd0; end
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_ready", 32'(last_ready), 32'd0);
    chk("idle_wb_en", 32'(wb_en), 32'd0);
    chk("idle_busy", busy_vec, 32'd0);

    // Single ALU request
    rd_a[0] = 5'd5; data_a[0] = 32'hDEAD_BEEF; req_valid = 3'b001;
    step();
    chk("alu_ready", 32'(last_ready), 32'd1);
    chk("alu_wb_en", 32'(wb_en), 32'd1);
    chk("alu_wb_rd", 32'(wb_rd), 32'd5);
    chk("alu_wb_data", wb_data, 32'hDEAD_BEEF);
    req_valid = 3'b000;
    step();
    chk("alu_wb_en_off", 32'(wb_en), 32'd0);

    // Round-robin vector table from a fresh pointer
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_a[i] = 5'(i + 1); data_a[i] = 32'hA000_0000 + 32'(i);
    end
    for (int i = 0; i < 12; i++) begin
      req_valid = tbl[i].valid;
      step();
      chk("rr_ready", 32'(last_ready), 32'(tbl[i].exp_ready));
      chk("rr_wb_en", 32'(wb_en), 32'(tbl[i].exp_ready != 3'b000));
      if (tbl[i].exp_ready != 3'b000) chk("rr_wb_rd", 32'(wb_rd), 32'(tbl[i].exp_rd));
    end
    req_valid = 3'b000;

    // Scoreboard RAW hazard through an MDU writeback
    sb_set = 1'b1; sb_set_rd = 5'd7;
    step();
    sb_set = 1'b0;
    chk("sb_set7", 32'(busy_vec[7]), 32'd1);
    chk_rs1 = 5'd7; rd_a[2] = 5'd7; data_a[2] = 32'h0000_0777; req_valid = 3'b100;
    step();
    chk("raw_hazard", 32'(last_hazard), 32'd1);
    chk("mdu_wb_rd", 32'(wb_rd), 32'd7);
    chk("hz_wb_cycle", 32'(hazard), 32'd1);
    req_valid = 3'b000;
    step();
    chk("hz_wb_late", 32'(last_hazard), 32'd1);
    chk("busy7_clr", 32'(busy_vec[7]), 32'd0);
    chk("hz_drop", 32'(hazard), 32'd0);
    chk_rs1 = 5'd0;

    // Set and clear of the same register in one cycle
    rd_a[0] = 5'd9; data_a[0] = 32'h0000_0009; req_valid = 3'b001;
    step();
    chk("wb9_en", 32'(wb_en), 32'd1);
    req_valid = 3'b000; sb_set = 1'b1; sb_set_rd = 5'd9;
    step();
    chk("set_wins", 32'(busy_vec[9]), 32'd1);
    sb_flush = 1'b1; sb_set_rd = 5'd4;
    step();
    sb_flush = 1'b0;
    chk("flush_wins", busy_vec, 32'd0);

    // LSU rd=0 transfer leaves write port and scoreboard alone
    sb_set_rd = 5'd12;
    step();
    sb_set = 1'b0;
    rd_a[1] = 5'd0; data_a[1] = 32'h0000_1234; req_valid = 3'b010;
    step();
    chk("rd0_ready", 32'(last_ready), 32'd2);
    chk("rd0_wb_en", 32'(wb_en), 32'd0);
    chk("rd0_busy", busy_vec, 32'h0000_1000);
    rd_a[0] = 5'd1; rd_a[2] = 5'd3; req_valid = 3'b111; sb_set = 1'b1; sb_set_rd = 5'd0;
    step();
    sb_set = 1'b0;
    chk("rd0_p_adv", 32'(last_ready), 32'd4);
    chk("set_rd0_hz", 32'(last_hazard), 32'd0);
    chk("set_rd0_busy", busy_vec, 32'h0000_1000);

    // Reset in the middle of a burst
    step();
    rst = 1'b1;
    step();
    chk("rst_ready", 32'(last_ready), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_busy", busy_vec, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_p0", 32'(last_ready), 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || last_ready[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          rd_a[i]      = 5'($urandom_range(0, 31));
          data_a[i]    = $urandom;
        end
      end
      rst       = ($urandom_range(0, 99) == 0);
      chk_rs1   = 5'($urandom_range(0, 31));
      chk_rs2   = 5'($urandom_range(0, 31));
      sb_flush  = ($urandom_range(0, 31) == 0);
      sb_set_rd = 5'($urandom_range(0, 31));
      sb_set    = 1'($urandom_range(0, 1));
      if (sb_set && m_hazard()) sb_set = 1'b0;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
